// File: rtl/frame_dump_sequencer.sv
// Dumps the downsampled thumbnail buffer over the uart on a debounced button press:
// two sync bytes, every pixel byte (x fastest, MSB first), then an 8-bit additive checksum.
module frame_dump_sequencer #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter int          X_W        = 6,
  parameter int          Y_W        = 5,
  parameter int          DEBOUNCE_W = 14,
  parameter int          HOLDOFF_W  = 13,
  parameter logic [7:0]  SYNC0      = 8'hA5,
  parameter logic [7:0]  SYNC1      = 8'h5A
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_i,
  input  logic           start_i,
  output logic [X_W-1:0] read_x_o,
  output logic [Y_W-1:0] read_y_o,
  input  logic [31:0]    read_q_i,
  input  logic           uart_busy_i,
  output logic           uart_wr_o,
  output logic [7:0]     uart_dat_o,
  output logic           busy_o,
  output logic           done_o
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, FETCH, WAIT, SEND, CSUM, DONE
  } state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  state_t                state_q, state_d;
  logic                  start_q, start_d;
  logic [DEBOUNCE_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [HOLDOFF_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [1:0]            z_q, z_d;
  logic [7:0]            csum_q, csum_d;
  logic [31:0]           shreg_q, shreg_d;
  logic                  wr_q, wr_d;
  logic [7:0]            dat_q, dat_d;
  logic                  done_q, done_d;

  logic deb_sat, hold_sat, can_wr, trigger;

  always_comb begin
    deb_sat  = &deb_cnt_q;
    hold_sat = &hold_cnt_q;
    // wr_q is included so the strobe itself blocks the next write before the uart reports busy
    can_wr   = hold_sat & ~uart_busy_i & ~wr_q;
    trigger  = start_q & deb_sat;

    start_d    = start_i;
    deb_cnt_d  = start_q ? '0 : (deb_sat ? deb_cnt_q : deb_cnt_q + 1'b1);
    hold_cnt_d = (uart_busy_i | wr_q) ? '0 : (hold_sat ? hold_cnt_q : hold_cnt_q + 1'b1);

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    csum_d  = csum_q;
    shreg_d = shreg_q;
    wr_d    = 1'b0;
    dat_d   = dat_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = HDR0;
          x_d     = '0;
          y_d     = '0;
          z_d     = '0;
          csum_d  = '0;
        end
      end
      HDR0: begin
        if (can_wr) begin
          wr_d    = 1'b1;
          dat_d   = SYNC0;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (can_wr) begin
          wr_d    = 1'b1;
          dat_d   = SYNC1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        // buffer word for the current address is valid on this edge
        shreg_d = read_q_i;
        state_d = SEND;
      end
      SEND: begin
        if (can_wr) begin
          wr_d    = 1'b1;
          dat_d   = shreg_q[31:24];
          shreg_d = {shreg_q[23:0], 8'h00};
          csum_d  = csum_q + shreg_q[31:24];
          z_d     = z_q + 2'd1;
          if (z_q == 2'd3) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
              state_d = CSUM;
            end else begin
              state_d = FETCH;
              if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + Y_W'(1);
              end else begin
                x_d = x_q + X_W'(1);
              end
            end
          end
        end
      end
      CSUM: begin
        if (can_wr) begin
          wr_d    = 1'b1;
          dat_d   = csum_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        x_d     = '0;
        y_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      csum_q     <= '0;
      shreg_q    <= '0;
      wr_q       <= 1'b0;
      dat_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      csum_q     <= csum_d;
      shreg_q    <= shreg_d;
      wr_q       <= wr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
    end
  end

  assign read_x_o   = x_q;
  assign read_y_o   = y_q;
  assign uart_wr_o  = wr_q;
  assign uart_dat_o = dat_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule

// File: tb/tb_frame_dump_sequencer.sv
// Directed bench for frame_dump_sequencer with a small 2x2 buffer, a registered
// buffer model and a uart model that stays busy for 10 cycles after each write.
module tb_frame_dump_sequencer;

  localparam int COLS = 2;
  localparam int ROWS = 2;
  localparam int X_W  = 6;
  localparam int Y_W  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b1;
  logic [X_W-1:0] read_x;
  logic [Y_W-1:0] read_y;
  logic [31:0]    read_q = '0;
  logic           uart_busy;
  logic           uart_wr;
  logic [7:0]     uart_dat;
  logic           busy;
  logic           done;

  int tests = 0;
  int fails = 0;

  logic       fill_ff = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] bytes[$];
  int         idle_cnt = 100;
  logic       prev_wr = 1'b0;
  int         spacing_viol = 0;
  int         b2b_viol = 0;
  int         done_cnt = 0;

  frame_dump_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W),
    .DEBOUNCE_W(4), .HOLDOFF_W(3), .SYNC0(8'hA5), .SYNC1(8'h5A)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .start_i    (start_i),
    .read_x_o   (read_x),
    .read_y_o   (read_y),
    .read_q_i   (read_q),
    .uart_busy_i(uart_busy),
    .uart_wr_o  (uart_wr),
    .uart_dat_o (uart_dat),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Buffer: one registered stage, so data is valid on the 2nd edge after an address change.
  always @(posedge clk)
    read_q <= fill_ff ? 32'hFFFF_FFFF : {8'(read_y), 8'(read_x), 8'hC3, 8'h3C};

  always @(posedge clk) begin
    if (uart_wr) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (uart_wr) begin
      bytes.push_back(uart_dat);
      if (uart_busy || idle_cnt < 7) spacing_viol++;
      if (prev_wr) b2b_viol++;
      idle_cnt = 0;
    end else if (uart_busy) begin
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
    prev_wr = uart_wr;
    if (done) done_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    start_i = 1'b0;
    cycles(20);
    start_i = 1'b1;
  endtask

  task automatic wait_done(input string name, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      cycles(1);
      n++;
    end
    tests++;
    if (done_cnt == d0) begin
      fails++;
      $display("FAIL %s_timeout: no done_o within %0d cycles", name, n);
    end
    cycles(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b1;
    cycles(3);
    rst = 1'b0;
    tests++;
    if (uart_wr !== 1'b0 || uart_dat !== 8'h00) begin
      fails++;
      $display("FAIL reset_uart: wr=%b dat=%h want 0/00", uart_wr, uart_dat);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: busy=%b done=%b want 0/0", busy, done);
    end
    tests++;
    if (read_x !== '0 || read_y !== '0) begin
      fails++;
      $display("FAIL reset_addr: x=%0d y=%0d want 0/0", read_x, read_y);
    end
    cycles(30);
    tests++;
    if (busy !== 1'b0 || bytes.size() != 0) begin
      fails++;
      $display("FAIL reset_held_start: busy=%b bytes=%0d want 0/0", busy, bytes.size());
    end
  endtask

  task automatic test_debounce();
    int n;
    bytes.delete();
    start_i = 1'b0;
    cycles(5);
    start_i = 1'b1;
    cycles(10);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL debounce_short: busy=%b want 0", busy);
    end
    start_i = 1'b0;
    cycles(15);
    start_i = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 5) begin
      cycles(1);
      n++;
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL debounce_full: busy=%b want 1", busy);
    end
  endtask

  task automatic test_full_dump();
    logic [7:0] exp [19] = '{8'hA5, 8'h5A,
                             8'h00, 8'h00, 8'hC3, 8'h3C, 8'h00, 8'h01, 8'hC3, 8'h3C,
                             8'h01, 8'h00, 8'hC3, 8'h3C, 8'h01, 8'h01, 8'hC3, 8'h3C,
                             8'h00};
    int d0;
    d0 = 0;
    wait_done("dump", d0);
    tests++;
    if (bytes.size() != 19) begin
      fails++;
      $display("FAIL dump_len: got %0d bytes want 19", bytes.size());
    end
    for (int i = 0; i < 19; i++) begin
      if (i < bytes.size()) begin
        tests++;
        if (bytes[i] !== exp[i]) begin
          fails++;
          $display("FAIL dump_byte%0d: got %h want %h", i, bytes[i], exp[i]);
        end
      end
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL dump_done_pulses: got %0d want 1", done_cnt);
    end
    tests++;
    if (busy !== 1'b0 || read_x !== '0 || read_y !== '0) begin
      fails++;
      $display("FAIL dump_end: busy=%b x=%0d y=%0d want 0/0/0", busy, read_x, read_y);
    end
    cycles(60);
    tests++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      fails++;
      $display("FAIL held_no_retrigger: busy=%b done_cnt=%0d want 0/1", busy, done_cnt);
    end
  endtask

  task automatic test_checksum();
    int d0;
    fill_ff = 1'b1;
    bytes.delete();
    d0 = done_cnt;
    press();
    wait_done("csum", d0);
    tests++;
    if (bytes.size() != 19) begin
      fails++;
      $display("FAIL csum_len: got %0d bytes want 19", bytes.size());
    end else begin
      for (int i = 2; i < 18; i++) begin
        tests++;
        if (bytes[i] !== 8'hFF) begin
          fails++;
          $display("FAIL csum_pixel%0d: got %h want ff", i, bytes[i]);
        end
      end
      tests++;
      if (bytes[18] !== 8'hF0) begin
        fails++;
        $display("FAIL csum_byte: got %h want f0", bytes[18]);
      end
    end
    fill_ff = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int n;
    int d0;
    bytes.delete();
    press();
    n = 0;
    while (!(uart_wr === 1'b1 && bytes.size() == 6) && n < 3000) begin
      cycles(1);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL rstmid_timeout: got %0d bytes want 7th strobe", bytes.size());
    end
    d0 = done_cnt;
    rst = 1'b1;
    cycles(1);
    tests++;
    if (uart_wr !== 1'b0 || uart_dat !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_outputs: wr=%b dat=%h busy=%b want 0/00/0", uart_wr, uart_dat, busy);
    end
    rst = 1'b0;
    cycles(40);
    tests++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      fails++;
      $display("FAIL rstmid_no_restart: busy=%b done_delta=%0d want 0/0", busy, done_cnt - d0);
    end
    bytes.delete();
    press();
    n = 0;
    while (bytes.size() == 0 && n < 500) begin
      cycles(1);
      n++;
    end
    tests++;
    if (bytes.size() == 0 || bytes[0] !== 8'hA5) begin
      fails++;
      $display("FAIL rstmid_restart: bytes=%0d first=%h want A5", bytes.size(),
               (bytes.size() != 0) ? bytes[0] : 8'h00);
    end
    wait_done("rstmid_redump", d0);
  endtask

  task automatic test_byte_spacing();
    tests++;
    if (spacing_viol != 0) begin
      fails++;
      $display("FAIL spacing: got %0d violations want 0", spacing_viol);
    end
    tests++;
    if (b2b_viol != 0) begin
      fails++;
      $display("FAIL back_to_back_strobe: got %0d want 0", b2b_viol);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_dump();
    test_checksum();
    test_reset_mid_dump();
    test_byte_spacing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
